// File: rtl/data_stack_pkg.sv
// Shared definitions for the hardware data stack.
// Op codes are shared with the CPU decode.
package data_stack_pkg;

  typedef enum logic [2:0] {
    STK_NOP   = 3'd0,
    STK_PUSH  = 3'd1,
    STK_POP   = 3'd2,
    STK_P2P   = 3'd3,
    STK_SWAP  = 3'd4,
    STK_DUP   = 3'd5,
    STK_OVER  = 3'd6,
    STK_NOP7  = 3'd7
  } stk_op_e;

  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;

endpackage

// File: rtl/stack_ram.sv
// Spill RAM for entries below TOS/NOS.
// Ports: clk, we/waddr/wdata (sync write), raddr/rdata (async read).
module stack_ram #(
  parameter int WIDTH = 16,
  parameter int WORDS = 14,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack.sv
// Data stack: TOS/NOS in registers, deeper entries in stack_ram.
// Ports: clk, rst, op, din, err_clr -> tos, nos, count, empty, full, err.
module data_stack
  import data_stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             err_clr,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic [1:0]       err
);

  localparam int WORDS = DEPTH - 2;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [WIDTH-1:0] tos_q, nos_q, tos_n, nos_n;
  logic [CW-1:0]    cnt_q, cnt_n, sp;
  logic [1:0]       err_q, err_n;
  logic             has1, has2, has3, is_full;
  logic             we, ovf, unf;
  logic [AW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] wdata, rdata;
  stk_op_e          op_e;

  assign op_e    = stk_op_e'(op);
  assign has1    = cnt_q >= CW'(1);
  assign has2    = cnt_q >= CW'(2);
  assign has3    = cnt_q >= CW'(3);
  assign is_full = cnt_q == CW'(DEPTH);

  // sp only meaningful with two or more entries; held at 0 otherwise
  assign sp    = has2 ? cnt_q - CW'(2) : '0;
  assign waddr = AW'(sp);
  assign raddr = has3 ? AW'(sp - CW'(1)) : '0;

  stack_ram #(
    .WIDTH (WIDTH),
    .WORDS (WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    tos_n = tos_q;
    nos_n = nos_q;
    cnt_n = cnt_q;
    we    = 1'b0;
    wdata = nos_q;
    ovf   = 1'b0;
    unf   = 1'b0;
    unique case (op_e)
      STK_PUSH: begin
        if (is_full) ovf = 1'b1;
        else begin
          we    = has2;
          nos_n = tos_q;
          tos_n = din;
          cnt_n = cnt_q + CW'(1);
        end
      end
      STK_POP: begin
        if (!has1) unf = 1'b1;
        else begin
          tos_n = nos_q;
          nos_n = has3 ? rdata : '0;
          cnt_n = cnt_q - CW'(1);
        end
      end
      STK_P2P: begin
        if (!has2) unf = 1'b1;
        else begin
          tos_n = din;
          nos_n = has3 ? rdata : '0;
          cnt_n = cnt_q - CW'(1);
        end
      end
      STK_SWAP: begin
        if (!has2) unf = 1'b1;
        else begin
          tos_n = nos_q;
          nos_n = tos_q;
        end
      end
      STK_DUP: begin
        if (!has1) unf = 1'b1;
        else if (is_full) ovf = 1'b1;
        else begin
          we    = has2;
          nos_n = tos_q;
          cnt_n = cnt_q + CW'(1);
        end
      end
      STK_OVER: begin
        if (!has2) unf = 1'b1;
        else if (is_full) ovf = 1'b1;
        else begin
          we    = 1'b1;
          nos_n = tos_q;
          tos_n = nos_q;
          cnt_n = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
    // a new error in the clear cycle still sets its bit
    err_n          = err_clr ? 2'b00 : err_q;
    err_n[ERR_OVF] = err_n[ERR_OVF] | ovf;
    err_n[ERR_UNF] = err_n[ERR_UNF] | unf;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tos_q <= '0;
      nos_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      tos_q <= tos_n;
      nos_q <= nos_n;
      cnt_q <= cnt_n;
      err_q <= err_n;
    end
  end

  assign tos   = tos_q;
  assign nos   = nos_q;
  assign count = cnt_q;
  assign empty = cnt_q == '0;
  assign full  = is_full;
  assign err   = err_q;

endmodule

// File: tb/tb_data_stack.sv
// Scoreboard bench for data_stack.
// Stimulus queues expected state; monitor checks after each edge.
module tb_data_stack;
  import data_stack_pkg::*;

  localparam int W = 16;
  localparam int D = 16;

  logic         clk = 0;
  logic         rst = 0;
  logic [2:0]   op = 0;
  logic [W-1:0] din = 0;
  logic         err_clr = 0;
  logic [W-1:0] tos, nos;
  logic [4:0]   count;
  logic         empty, full;
  logic [1:0]   err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    int         t;
    int         n;
    int         c;
    logic [1:0] e;
  } exp_t;

  exp_t sb[$];

  data_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .op      (op),
    .din     (din),
    .err_clr (err_clr),
    .tos     (tos),
    .nos     (nos),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .err     (err)
  );

  always #5 clk = ~clk;

  function automatic void check(exp_t x);
    logic ee, ef;
    ee = (x.c == 0);
    ef = (x.c == D);
    total++;
    if (tos !== W'(x.t) || nos !== W'(x.n) || count !== 5'(x.c) ||
        empty !== ee || full !== ef || err !== x.e) begin
      bad++;
      $display("FAIL %s: got tos=%0d nos=%0d cnt=%0d emp=%b full=%b err=%b want tos=%0d nos=%0d cnt=%0d emp=%b full=%b err=%b",
               x.name, tos, nos, count, empty, full, err,
               x.t, x.n, x.c, ee, ef, x.e);
    end
  endfunction

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check(x);
      end
    end
  end

  task automatic step(input string nm, input logic [2:0] o,
                      input int d, input logic clr,
                      input int et, input int en, input int ec,
                      input logic [1:0] ee);
    exp_t x;
    @(negedge clk);
    op      = o;
    din     = W'(d);
    err_clr = clr;
    x.name = nm; x.t = et; x.n = en; x.c = ec; x.e = ee;
    sb.push_back(x);
  endtask

  task automatic idle();
    @(negedge clk);
    op      = STK_NOP;
    err_clr = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    exp_t x;
    idle();
    #1;
    rst = 1'b1;
    #1;
    x.name = nm; x.t = 0; x.n = 0; x.c = 0; x.e = 2'b00;
    check(x);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : stim
    int k;
    do_reset("reset0");

    step("push5", STK_PUSH, 5, 0, 5, 0, 1, 2'b00);
    step("push7", STK_PUSH, 7, 0, 7, 5, 2, 2'b00);
    step("p2p12", STK_P2P, 12, 0, 12, 0, 1, 2'b00);
    do_reset("reset1");

    for (int i = 1; i <= 16; i++)
      step("fill", STK_PUSH, i, 0, i, i - 1, i, 2'b00);
    step("ovf", STK_PUSH, 99, 0, 16, 15, 16, 2'b01);
    for (int i = 1; i <= 16; i++) begin
      k = 16 - i;
      step("drain", STK_POP, 0, 0, k, (k >= 2) ? k - 1 : 0, k, 2'b01);
    end
    do_reset("reset2");

    step("unf", STK_POP, 0, 0, 0, 0, 0, 2'b10);
    step("clrpush", STK_PUSH, 3, 1, 3, 0, 1, 2'b00);
    step("swap1", STK_SWAP, 0, 0, 3, 0, 1, 2'b10);
    step("clrerr", STK_NOP, 0, 1, 3, 0, 1, 2'b00);
    step("dup1", STK_DUP, 0, 0, 3, 3, 2, 2'b00);
    do_reset("reset3");

    step("p1", STK_PUSH, 1, 0, 1, 0, 1, 2'b00);
    step("p2", STK_PUSH, 2, 0, 2, 1, 2, 2'b00);
    step("p3", STK_PUSH, 3, 0, 3, 2, 3, 2'b00);
    step("swap", STK_SWAP, 0, 0, 2, 3, 3, 2'b00);
    step("over", STK_OVER, 0, 0, 3, 2, 4, 2'b00);
    step("dup", STK_DUP, 0, 0, 3, 3, 5, 2'b00);
    step("pop_a", STK_POP, 0, 0, 3, 2, 4, 2'b00);
    step("pop_b", STK_POP, 0, 0, 2, 3, 3, 2'b00);
    step("pop_c", STK_POP, 0, 0, 3, 1, 2, 2'b00);
    step("pop_d", STK_POP, 0, 0, 1, 0, 1, 2'b00);
    step("pop_e", STK_POP, 0, 0, 0, 0, 0, 2'b00);
    step("op7", 3'd7, 0, 0, 0, 0, 0, 2'b00);
    do_reset("reset4");

    step("b10", STK_PUSH, 10, 0, 10, 0, 1, 2'b00);
    step("b20", STK_PUSH, 20, 0, 20, 10, 2, 2'b00);
    step("b4", STK_PUSH, 4, 0, 4, 20, 3, 2'b00);
    step("bpop", STK_POP, 0, 0, 20, 10, 2, 2'b00);
    step("bp2p", STK_P2P, 30, 0, 30, 0, 1, 2'b00);
    step("p2p_unf", STK_P2P, 1, 0, 30, 0, 1, 2'b10);
    do_reset("reset5");

    for (int i = 1; i <= 6; i++)
      step("six", STK_PUSH, 40 + i, 0, 40 + i, (i > 1) ? 39 + i : 0, i, 2'b00);
    do_reset("reset_mid");
    step("post_unf", STK_POP, 0, 0, 0, 0, 0, 2'b10);
    idle();

    for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got pending=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
